// File: rtl/sync_fifo_flagged_if.sv
// Handshake and status bundle between a sync_fifo_flagged instance and the
// producer/consumer logic that shares its clock.
interface sync_fifo_flagged_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) ();
  logic [WIDTH-1:0] data_in;
  logic             w_en;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic             half_full;
  logic [CNT_W-1:0] count;

  modport master (
    output data_in, w_en, r_en,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, half_full, count
  );

  modport slave (
    input  data_in, w_en, r_en,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, half_full, count
  );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with write acknowledge, overflow/underflow strobes,
// threshold flags, occupancy count and optional first-word-fall-through read.
module sync_fifo_flagged #(
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter bit FWFT          = 1'b0
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_flagged_if.slave fifo
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(FIFO_DEPTH / 2);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flagged: FIFO_DEPTH must be at least 2");
  end
  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flagged: FIFO_WIDTH must be at least 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH - 1) begin : g_bad_afull
    $error("sync_fifo_flagged: AFULL_THRESH must be in 1..FIFO_DEPTH-1");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flagged: AEMPTY_THRESH must be in 0..FIFO_DEPTH-1");
  end

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [FIFO_WIDTH-1:0] head_word;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign wr_acc    = fifo.w_en & ~full;
  assign rd_acc    = fifo.r_en & ~empty;
  assign head_word = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = wr_acc;
    overflow_d  = fifo.w_en & full;
    underflow_d = fifo.r_en & empty;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left uncleared by reset; only occupancy matters.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= fifo.data_in;
    end
  end

  assign fifo.data_out    = FWFT ? head_word : data_out_q;
  assign fifo.wr_ack      = wr_ack_q;
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;
  assign fifo.full        = full;
  assign fifo.empty       = empty;
  assign fifo.almostfull  = (count_q >= AFULL_C) && (count_q < DEPTH_C);
  assign fifo.almostempty = (count_q <= AEMPTY_C) && (count_q != '0);
  assign fifo.half_full   = (count_q >= HALF_C);
  assign fifo.count       = count_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: a registered-read instance driven from a vector
// table plus corner sequences, and a first-word-fall-through instance.
module tb_sync_fifo_flagged;

  typedef struct {
    logic        rs;
    logic        w;
    logic        r;
    logic [15:0] d;
    int          cnt;
    logic        ack;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic clk;
  logic rst;

  int total;
  int bad;
  int model_cnt;
  logic [15:0] exp_data;
  logic [15:0] sb[$];
  vec_t vecs[21];

  sync_fifo_flagged_if #(.WIDTH(16), .CNT_W(4)) bus0 ();
  sync_fifo_flagged_if #(.WIDTH(16), .CNT_W(4)) bus1 ();

  sync_fifo_flagged #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus0.slave)
  );

  sync_fifo_flagged #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the registered-read instance; data expectations come from the scoreboard.
  task automatic apply_stimulus(input logic rs, input logic w, input logic r,
                                input logic [15:0] d, input int cnt,
                                input logic ack, input logic ovf, input logic unf,
                                input string tag);
    rst          = rs;
    bus0.w_en    = w;
    bus0.r_en    = r;
    bus0.data_in = d;
    if (rs) begin
      sb.delete();
      exp_data = 16'h0000;
    end else begin
      if (r && model_cnt > 0) begin
        if (sb.size() > 0) exp_data = sb.pop_front();
      end
      if (ack) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus0.w_en    = 1'b0;
    bus0.r_en    = 1'b0;
    check_output({tag, " count"},       32'(bus0.count), 32'(cnt));
    check_output({tag, " wr_ack"},      32'(bus0.wr_ack), 32'(ack));
    check_output({tag, " overflow"},    32'(bus0.overflow), 32'(ovf));
    check_output({tag, " underflow"},   32'(bus0.underflow), 32'(unf));
    check_output({tag, " data_out"},    32'(bus0.data_out), 32'(exp_data));
    check_output({tag, " full"},        32'(bus0.full), 32'(cnt == 8));
    check_output({tag, " empty"},       32'(bus0.empty), 32'(cnt == 0));
    check_output({tag, " almostfull"},  32'(bus0.almostfull), 32'(cnt >= 7 && cnt < 8));
    check_output({tag, " almostempty"}, 32'(bus0.almostempty), 32'(cnt <= 1 && cnt > 0));
    check_output({tag, " half_full"},   32'(bus0.half_full), 32'(cnt >= 4));
    model_cnt = cnt;
  endtask

  task automatic fwft_step(input logic w, input logic r, input logic [15:0] d,
                           input int cnt, input logic [15:0] dout, input string tag);
    bus1.w_en    = w;
    bus1.r_en    = r;
    bus1.data_in = d;
    @(posedge clk);
    #1;
    bus1.w_en = 1'b0;
    bus1.r_en = 1'b0;
    check_output({tag, " count"},    32'(bus1.count), 32'(cnt));
    check_output({tag, " empty"},    32'(bus1.empty), 32'(cnt == 0));
    check_output({tag, " data_out"}, 32'(bus1.data_out), 32'(dout));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    model_cnt    = 0;
    exp_data     = 16'h0000;
    rst          = 1'b1;
    bus0.w_en    = 1'b0;
    bus0.r_en    = 1'b0;
    bus0.data_in = 16'h0000;
    bus1.w_en    = 1'b0;
    bus1.r_en    = 1'b0;
    bus1.data_in = 16'h0000;

    // Reset, fill to full, overflow, drain to empty, underflow.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[2+i] = '{1'b0, 1'b1, 1'b0, 16'(i + 1), i + 1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'hDEAD, 8, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[11+i] = '{1'b0, 1'b0, 1'b1, 16'h0000, 7 - i, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 21; i++)
      apply_stimulus(vecs[i].rs, vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].cnt,
                     vecs[i].ack, vecs[i].ovf, vecs[i].unf, $sformatf("vec%0d", i));

    // Steady simultaneous traffic at count 4, crossing the pointer wrap.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i), i + 1, 1'b1, 1'b0, 1'b0, "prefill");
    for (int i = 0; i < 20; i++)
      apply_stimulus(1'b0, 1'b1, 1'b1, 16'(16'h0200 + i), 4, 1'b1, 1'b0, 1'b0, "rw_mid");

    // Both requests while full, then both requests while empty.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'(16'h0300 + i), i + 5, 1'b1, 1'b0, 1'b0, "refill");
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'hDEAD, 7, 1'b0, 1'b1, 1'b0, "rw_full");
    for (int i = 0; i < 7; i++)
      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000, 6 - i, 1'b0, 1'b0, 1'b0, "drain");
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h0BAD, 1, 1'b1, 1'b0, 1'b1, "rw_empty");
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0, "rd_bad");

    // Reset in the middle of a burst drops the coincident write.
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'(16'h0400 + i), i + 1, 1'b1, 1'b0, 1'b0, "burst");
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'hBEEF, 0, 1'b0, 1'b0, 1'b0, "rst_mid");
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0, "post_rst");
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1234, 1, 1'b1, 1'b0, 1'b0, "wr_after");
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0, "rd_after");

    // First-word-fall-through instance.
    check_output("fwft idle data_out", 32'(bus1.data_out), 32'h0);
    fwft_step(1'b1, 1'b0, 16'hA5A5, 1, 16'hA5A5, "fwft wr1");
    fwft_step(1'b0, 1'b0, 16'h0000, 1, 16'hA5A5, "fwft hold");
    fwft_step(1'b1, 1'b0, 16'h5A5A, 2, 16'hA5A5, "fwft wr2");
    fwft_step(1'b0, 1'b1, 16'h0000, 1, 16'h5A5A, "fwft pop1");
    fwft_step(1'b0, 1'b1, 16'h0000, 0, 16'h0000, "fwft pop2");
    fwft_step(1'b0, 1'b1, 16'h0000, 0, 16'h0000, "fwft pop3");
    check_output("fwft underflow", 32'(bus1.underflow), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
